input_mems_pp: RTL and testbench

Ping-pong input memory for the 2D convolution accelerator. It loads W, B and X frames from an AXI-Stream slave into on-chip storage and serves single-ported read addresses to the compute engine. X storage is double-buffered, so frame n+1 streams in while the compute engine works on frame n. W/B/K are kept across frames until a frame header requests new weights.

---
 rtl/input_mems_pp.sv | 169 ++++++++++++++++
 tb/tb_input_mems_pp.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_mems_pp.sv
`default_nettype none
// ============================================================================
//  Module   : input_mems_pp
//  Purpose  : Input memory for the 2D convolution engine. Loads W, B and X
//             frames from an AXI-Stream slave and serves registered reads.
//             Define INPUT_MEMS_PINGPONG_EN for two X banks (load of frame n+1
//             overlaps compute of frame n). Without it a single X bank is
//             used and load/compute strictly alternate.
//  Revision : 1.0  initial release
// ============================================================================
module input_mems_pp #(
  parameter  int INW         = 24,
  parameter  int R           = 9,
  parameter  int C           = 8,
  parameter  int MAXK        = 4,
  localparam int K_BITS      = $clog2(MAXK + 1),
  localparam int X_ADDR_BITS = $clog2(R * C),
  localparam int W_ADDR_BITS = $clog2(MAXK * MAXK)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INW-1:0]                AXIS_TDATA,
  input  logic                          AXIS_TVALID,
  input  logic [K_BITS:0]               AXIS_TUSER,
  output logic                          AXIS_TREADY,
  output logic                          inputs_loaded,
  input  logic                          compute_finished,
  output logic [K_BITS-1:0]             K,
  output logic signed [INW-1:0]         B,
  input  logic [X_ADDR_BITS-1:0]        X_read_addr,
  output logic signed [INW-1:0]         X_data,
  input  logic [W_ADDR_BITS-1:0]        W_read_addr,
  output logic signed [INW-1:0]         W_data
);

`ifdef INPUT_MEMS_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int XN = R * C;
  localparam int WN = MAXK * MAXK;
  localparam int KK_BITS = 2 * K_BITS;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_W   = 2'd1,
    S_B   = 2'd2,
    S_X   = 2'd3
  } state_t;

  state_t                 state;
  logic [NB-1:0]          full;
  logic                   wr_bank;
  logic                   rd_bank;
  logic [W_ADDR_BITS-1:0] w_cnt;
  logic [X_ADDR_BITS-1:0] x_cnt;

  logic [INW-1:0] x_mem [NB][XN];
  logic [INW-1:0] w_mem [WN];

  logic                   hdr_new_w;
  logic [K_BITS-1:0]      hdr_k;
  logic [KK_BITS-1:0]     kk_hdr;
  logic [KK_BITS-1:0]     kk_cur;
  logic                   ready;
  logic                   accept;
  logic                   x_we;
  logic                   w_we;
  logic [X_ADDR_BITS-1:0] x_waddr;
  logic [W_ADDR_BITS-1:0] w_waddr;
  logic                   x_last;
  logic [NB-1:0]          set_mask;
  logic [NB-1:0]          clr_mask;

`ifndef INPUT_MEMS_PINGPONG_EN
  // Single bank: both pointers permanently select bank 0.
  assign wr_bank = 1'b0;
  assign rd_bank = 1'b0;
`endif

  // Header decode; a K field of zero is treated as K=1.
  assign hdr_new_w = AXIS_TUSER[0];
  assign hdr_k     = (AXIS_TUSER[K_BITS:1] == '0) ? K_BITS'(1) : AXIS_TUSER[K_BITS:1];
  assign kk_hdr    = KK_BITS'(hdr_k) * KK_BITS'(hdr_k);
  assign kk_cur    = KK_BITS'(K) * KK_BITS'(K);

  // Only the header beat can stall: it waits for an empty write bank, and a
  // weight change additionally waits for every bank to drain.
  always_comb begin
    ready = 1'b1;
    if (state == S_HDR)
      ready = !full[wr_bank] && (!hdr_new_w || (full == '0));
  end

  assign AXIS_TREADY   = reset && ready;
  assign accept        = AXIS_TVALID && AXIS_TREADY;
  assign inputs_loaded = full[rd_bank];

  assign x_we    = accept && (((state == S_HDR) && !hdr_new_w) || (state == S_X));
  assign w_we    = accept && (((state == S_HDR) && hdr_new_w) || (state == S_W));
  assign x_waddr = (state == S_HDR) ? '0 : x_cnt;
  assign w_waddr = (state == S_HDR) ? '0 : w_cnt;
  assign x_last  = accept && (state == S_X) && (x_cnt == X_ADDR_BITS'(XN - 1));
  assign set_mask = x_last ? (NB'(1) << wr_bank) : '0;
  assign clr_mask = (compute_finished && full[rd_bank]) ? (NB'(1) << rd_bank) : '0;

  // Storage writes; memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (x_we) x_mem[wr_bank][x_waddr] <= AXIS_TDATA;
    if (w_we) w_mem[w_waddr] <= AXIS_TDATA;
  end

  // Loader FSM, bank bookkeeping and registered read ports.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_HDR;
      full   <= '0;
      K      <= '0;
      B      <= '0;
      w_cnt  <= '0;
      x_cnt  <= '0;
      X_data <= '0;
      W_data <= '0;
`ifdef INPUT_MEMS_PINGPONG_EN
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
`endif
    end else begin
      X_data <= x_mem[rd_bank][X_read_addr];
      W_data <= w_mem[W_read_addr];
      // Set and clear target different banks, so both may land together.
      full   <= (full & ~clr_mask) | set_mask;
`ifdef INPUT_MEMS_PINGPONG_EN
      if (x_last)           wr_bank <= ~wr_bank;
      if (clr_mask != '0)   rd_bank <= ~rd_bank;
`endif
      if (accept) begin
        case (state)
          S_HDR: begin
            if (hdr_new_w) begin
              K     <= hdr_k;
              w_cnt <= W_ADDR_BITS'(1);
              state <= (kk_hdr == KK_BITS'(1)) ? S_B : S_W;
            end else begin
              x_cnt <= X_ADDR_BITS'(1);
              state <= S_X;
            end
          end
          S_W: begin
            w_cnt <= w_cnt + W_ADDR_BITS'(1);
            if (KK_BITS'(w_cnt) == kk_cur - KK_BITS'(1)) state <= S_B;
          end
          S_B: begin
            B     <= AXIS_TDATA;
            x_cnt <= '0;
            state <= S_X;
          end
          default: begin
            x_cnt <= x_cnt + X_ADDR_BITS'(1);
            if (x_cnt == X_ADDR_BITS'(XN - 1)) state <= S_HDR;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_mems_pp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_mems_pp
//  Purpose  : Self-checking bench for input_mems_pp. Frames are modelled as a
//             FIFO of (K, B, W snapshot, X image); reads are scored against
//             the frame at the head of that FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module tb_input_mems_pp;
  localparam int INW  = 24;
  localparam int R    = 9;
  localparam int C    = 8;
  localparam int MAXK = 4;
  localparam int XN   = R * C;
  localparam int WN   = MAXK * MAXK;
  localparam int TMO  = 3000;
  localparam int NF   = 10;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [INW-1:0]        AXIS_TDATA = '0;
  logic                  AXIS_TVALID = 1'b0;
  logic [3:0]            AXIS_TUSER = '0;
  logic                  AXIS_TREADY;
  logic                  inputs_loaded;
  logic                  compute_finished = 1'b0;
  logic [2:0]            K;
  logic signed [INW-1:0] B;
  logic [6:0]            X_read_addr = '0;
  logic signed [INW-1:0] X_data;
  logic [3:0]            W_read_addr = '0;
  logic signed [INW-1:0] W_data;

  input_mems_pp #(.INW(INW), .R(R), .C(C), .MAXK(MAXK)) dut (
    .clk(clk), .reset(reset),
    .AXIS_TDATA(AXIS_TDATA), .AXIS_TVALID(AXIS_TVALID), .AXIS_TUSER(AXIS_TUSER),
    .AXIS_TREADY(AXIS_TREADY), .inputs_loaded(inputs_loaded),
    .compute_finished(compute_finished), .K(K), .B(B),
    .X_read_addr(X_read_addr), .X_data(X_data),
    .W_read_addr(W_read_addr), .W_data(W_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int beats  = 0;

  // Reference model: current weights plus a FIFO of complete frames.
  logic signed [INW-1:0] tx_w [WN];
  logic signed [INW-1:0] tx_x [XN];
  logic signed [INW-1:0] tx_b;
  logic signed [INW-1:0] m_w [WN];
  int                    m_k = 0;
  logic signed [INW-1:0] m_b = '0;
  int                    fk [$];
  logic signed [INW-1:0] fb [$];
  logic signed [INW-1:0] fw [$];
  logic signed [INW-1:0] fx [$];
  // Read scoreboard.
  logic signed [INW-1:0] qx [$];
  logic signed [INW-1:0] qw [$];
  logic signed [INW-1:0] ex, ew;
  logic rd_req = 1'b0;
  logic rd_dly = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic abort(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: no response within %0d cycles", nm, TMO);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  endtask

  // Monitor: every registered read is compared one cycle after issue.
  always @(posedge clk) rd_dly <= rd_req;
  always @(negedge clk) begin
    if (rd_dly) begin
      if (qx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_scoreboard: got read data, required none pending");
      end else begin
        ex = qx.pop_front();
        ew = qw.pop_front();
        chk("X_data", X_data, ex);
        chk("W_data", W_data, ew);
      end
    end
  end

  task automatic send_beat(input logic [INW-1:0] d, input logic [3:0] u, output int stalls);
    stalls = 0;
    AXIS_TDATA  = d;
    AXIS_TUSER  = u;
    AXIS_TVALID = 1'b1;
    @(negedge clk);
    while (!AXIS_TREADY) begin
      stalls++;
      if (stalls >= TMO) abort("tready_wait");
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    beats++;
  endtask

  // Streams one frame (nx X beats); a complete frame is committed to the model.
  task automatic send_frame(input bit nw, input int kf, input int nx, output int hs, output int ds);
    int s, k, kk;
    logic [2:0] kfield;
    k  = (kf == 0) ? 1 : kf;
    kk = k * k;
    ds = 0;
    kfield = 3'(kf);
    if (nw) begin
      send_beat(tx_w[0], {kfield, 1'b1}, hs);
      for (int i = 1; i < kk; i++) begin send_beat(tx_w[i], 4'd0, s); ds += s; end
      send_beat(tx_b, 4'd0, s); ds += s;
      for (int i = 0; i < nx; i++) begin send_beat(tx_x[i], 4'd0, s); ds += s; end
    end else begin
      send_beat(tx_x[0], 4'd0, hs);
      for (int i = 1; i < nx; i++) begin send_beat(tx_x[i], 4'd0, s); ds += s; end
    end
    AXIS_TVALID = 1'b0;
    if (nx == XN) begin
      if (nw) begin
        m_k = k;
        m_b = tx_b;
        for (int i = 0; i < kk; i++) m_w[i] = tx_w[i];
      end
      fk.push_back(m_k);
      fb.push_back(m_b);
      for (int i = 0; i < WN; i++) fw.push_back(m_w[i]);
      for (int i = 0; i < XN; i++) fx.push_back(tx_x[i]);
    end
  endtask

  task automatic randomize_tx();
    for (int i = 0; i < WN; i++) tx_w[i] = INW'($urandom);
    for (int i = 0; i < XN; i++) tx_x[i] = INW'($urandom);
    tx_b = INW'($urandom);
  endtask

  task automatic issue_read(input int xa, input int wa);
    X_read_addr = 7'(xa);
    W_read_addr = 4'(wa);
    qx.push_back(fx[xa]);
    qw.push_back(fw[wa]);
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic consume(input int nr);
    if (fk.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL spurious_loaded: got inputs_loaded=1, required 0 with no frame");
    end else begin
      chk("K", K, fk[0]);
      chk("B", B, fb[0]);
      for (int i = 0; i < nr; i++)
        issue_read($urandom_range(0, XN - 1), $urandom_range(0, fk[0] * fk[0] - 1));
    end
  endtask

  task automatic release_frame();
    compute_finished = 1'b1;
    @(posedge clk);
    #1;
    compute_finished = 1'b0;
    if (fk.size() != 0) begin
      void'(fk.pop_front());
      void'(fb.pop_front());
      for (int i = 0; i < WN; i++) void'(fw.pop_front());
      for (int i = 0; i < XN; i++) void'(fx.pop_front());
    end
  endtask

  task automatic wait_loaded();
    int n;
    n = 0;
    @(negedge clk);
    while (!inputs_loaded) begin
      n++;
      if (n >= TMO) abort("inputs_loaded_wait");
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    chk({tag, "_tready"}, AXIS_TREADY, 0);
    chk({tag, "_loaded"}, inputs_loaded, 0);
    chk({tag, "_K"}, K, 0);
    chk({tag, "_B"}, B, 0);
    chk({tag, "_X_data"}, X_data, 0);
    chk({tag, "_W_data"}, W_data, 0);
  endtask

  initial begin
    int hs, ds, b0;

    // Reset state.
    repeat (2) @(posedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Frame 1: K=3, W=1..9, B=-5, X=0..71.
    for (int i = 0; i < WN; i++) tx_w[i] = INW'(i + 1);
    for (int i = 0; i < XN; i++) tx_x[i] = INW'(i);
    tx_b = -24'sd5;
    send_frame(1'b1, 3, XN, hs, ds);
    chk("f1_fullrate_stalls", ds, 0);
    chk("f1_loaded_after_last", inputs_loaded, 1);
    chk("f1_K", K, 3);
    chk("f1_B", B, -5);
    issue_read(71, 4);
    issue_read(0, 0);

    // Frame 2: X=100..171 with no new weights.
    for (int i = 0; i < XN; i++) tx_x[i] = INW'(100 + i);
`ifdef INPUT_MEMS_PINGPONG_EN
    send_frame(1'b0, 0, XN, hs, ds);
    chk("f2_hdr_stalls", hs, 0);
    chk("f2_fullrate_stalls", ds, 0);
    AXIS_TVALID = 1'b1;
    AXIS_TUSER  = 4'd0;
    repeat (3) @(negedge clk);
    chk("third_hdr_tready", AXIS_TREADY, 0);
    @(posedge clk); #1;
    AXIS_TVALID = 1'b0;
    release_frame();
    chk("loaded_stays_high", inputs_loaded, 1);
`else
    b0 = beats;
    fork
      send_frame(1'b0, 0, XN, hs, ds);
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("f2_hdr_stalled_while_full", beats - b0, 0);
        chk("f1_still_loaded", inputs_loaded, 1);
        release_frame();
        chk("loaded_falls_after_cf", inputs_loaded, 0);
      end
    join
    chk("f2_fullrate_stalls", ds, 0);
    chk("f2_loaded", inputs_loaded, 1);
`endif
    issue_read(0, 8);
    consume(2);

    // New-weights header while a frame is still held.
    randomize_tx();
    b0 = beats;
    fork
      send_frame(1'b1, 2, XN, hs, ds);
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("neww_hdr_stalled", beats - b0, 0);
        release_frame();
      end
    join
    chk("f3_loaded", inputs_loaded, 1);
    consume(4);
    release_frame();

    // compute_finished with nothing loaded must be ignored.
    chk("idle_not_loaded", inputs_loaded, 0);
    compute_finished = 1'b1;
    @(posedge clk); #1;
    compute_finished = 1'b0;
    @(posedge clk); #1;
    chk("idle_cf_ignored", inputs_loaded, 0);
    randomize_tx();
    send_frame(1'b0, 0, XN, hs, ds);
    chk("f4_hdr_stalls", hs, 0);
    chk("f4_loaded", inputs_loaded, 1);
    consume(4);
    release_frame();

    // Reset during X beat 30, then a fresh K=2 frame.
    randomize_tx();
    send_frame(1'b1, 3, 30, hs, ds);
    reset = 1'b0;
    check_reset_values("midreset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    m_k = 0;
    m_b = '0;
    randomize_tx();
    send_frame(1'b1, 2, XN, hs, ds);
    chk("post_reset_hdr_stalls", hs, 0);
    chk("post_reset_loaded", inputs_loaded, 1);
    consume(4);
    release_frame();

    // Randomized producer/consumer traffic.
    fork
      begin
        int phs, pds;
        for (int f = 0; f < NF; f++) begin
          randomize_tx();
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          send_frame(1'($urandom_range(0, 1)), $urandom_range(0, MAXK), XN, phs, pds);
          chk("rand_fullrate_stalls", pds, 0);
        end
      end
      begin
        for (int f = 0; f < NF; f++) begin
          wait_loaded();
          consume(3);
          repeat ($urandom_range(0, 20)) @(posedge clk);
          #1;
          release_frame();
        end
      end
    join

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", qx.size(), 0);
    chk("frames_drained", fk.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
